// File: rtl/instr_fetch_pkg.sv
// Shared types, FSM encoding and the unprefixed Game Boy immediate-length
// table used by the gb2 instruction fetch stage.
package instr_fetch_pkg;

    typedef logic [7:0]  r8_t;
    typedef logic [15:0] r16_t;

    typedef enum logic [2:0] {
        IDLE,
        OPCODE,
        CB,
        IMM_LO,
        IMM_HI,
        HOLD
    } fetch_state_t;

    localparam r8_t CB_PREFIX_DEFAULT = 8'hCB;

    // Number of immediate bytes that follow an unprefixed opcode. The CB
    // prefix itself reports 0 here; the fetch FSM routes it to its own page.
    function automatic logic [1:0] op_imm_len(input r8_t op);
        case (op)
            // d16 / a16 operands: LD rr,d16, LD (a16),SP, JP, CALL, LD (a16)/A
            8'h01, 8'h11, 8'h21, 8'h31,
            8'h08,
            8'hC2, 8'hC3, 8'hCA, 8'hD2, 8'hDA,
            8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC,
            8'hEA, 8'hFA:
                op_imm_len = 2'd2;
            // d8 / r8 / a8 operands: LD r,d8, STOP, JR, ALU d8, LDH, SP offsets
            8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
            8'h10,
            8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
            8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
            8'hE0, 8'hF0,
            8'hE8, 8'hF8:
                op_imm_len = 2'd1;
            default:
                op_imm_len = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/instr_fetch_op_len_rom.sv
// Combinational immediate-length lookup; kept separate so the opcode table
// can be replaced or exercised on its own.
module op_len_rom
    import instr_fetch_pkg::*;
(
    input  r8_t        op,
    output logic [1:0] imm_len
);

    assign imm_len = op_imm_len(op);

endmodule

// File: rtl/instr_fetch.sv
// gb2 instruction fetch stage: reads opcode, optional CB page byte and up to
// two immediates, writes PC/IR to the register file, hands off via valid/ready.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter r8_t CB_PREFIX = CB_PREFIX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_start,
    input  logic        flush,
    input  logic [15:0] r_pc,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        pc_wen,
    output logic [15:0] w_pc,
    output logic        ir_wen,
    output logic [7:0]  w_ir,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  instr_op,
    output logic        instr_cb,
    output logic [15:0] instr_imm,
    output logic [1:0]  instr_len
);

    fetch_state_t state;
    fetch_state_t state_nxt;

    r16_t       fetch_addr;
    r8_t        op_q;
    logic       cb_q;
    r8_t        imm_lo_q;
    r8_t        imm_hi_q;
    logic [1:0] len_q;
    logic [1:0] imm_len_q;

    logic [1:0] rom_len;
    logic       in_fetch;
    logic       ack_ok;
    logic       start_ok;
    logic       is_prefix;

    op_len_rom u_op_len_rom (
        .op      (mem_rdata),
        .imm_len (rom_len)
    );

    assign in_fetch  = (state == OPCODE) || (state == CB) ||
                       (state == IMM_LO) || (state == IMM_HI);
    // A read completing in a flush cycle is dropped entirely.
    assign ack_ok    = in_fetch && mem_ack && !flush;
    assign start_ok  = !flush && fetch_start &&
                       ((state == IDLE) || ((state == HOLD) && instr_ready));
    assign is_prefix = (mem_rdata == CB_PREFIX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: registers are always written with <= so every flop samples
            // the pre-edge value of its neighbours, independent of block order.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would otherwise infer a latch.
        state_nxt = state;
        pc_wen    = 1'b0;
        w_pc      = 16'h0000;
        ir_wen    = 1'b0;
        w_ir      = 8'h00;

        if (ack_ok) begin
            pc_wen = 1'b1;
            w_pc   = fetch_addr + 16'd1;
        end

        case (state)
            IDLE: begin
                if (start_ok) state_nxt = OPCODE;
            end
            OPCODE: begin
                if (ack_ok) begin
                    if (is_prefix) begin
                        state_nxt = CB;
                    end else begin
                        ir_wen    = 1'b1;
                        w_ir      = mem_rdata;
                        state_nxt = (rom_len != 2'd0) ? IMM_LO : HOLD;
                    end
                end
            end
            CB: begin
                if (ack_ok) begin
                    ir_wen    = 1'b1;
                    w_ir      = mem_rdata;
                    state_nxt = HOLD;
                end
            end
            IMM_LO: begin
                if (ack_ok) state_nxt = (imm_len_q == 2'd2) ? IMM_HI : HOLD;
            end
            IMM_HI: begin
                if (ack_ok) state_nxt = HOLD;
            end
            HOLD: begin
                if (instr_ready) state_nxt = start_ok ? OPCODE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (flush) state_nxt = IDLE;
    end

    // Holding registers: cleared when a new fetch is launched, filled per ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_addr <= 16'h0000;
            op_q       <= 8'h00;
            cb_q       <= 1'b0;
            imm_lo_q   <= 8'h00;
            imm_hi_q   <= 8'h00;
            len_q      <= 2'd0;
            imm_len_q  <= 2'd0;
        end else if (start_ok) begin
            fetch_addr <= r_pc;
            cb_q       <= 1'b0;
            imm_lo_q   <= 8'h00;
            imm_hi_q   <= 8'h00;
            len_q      <= 2'd0;
            imm_len_q  <= 2'd0;
        end else if (ack_ok) begin
            fetch_addr <= fetch_addr + 16'd1;
            len_q      <= len_q + 2'd1;
            case (state)
                OPCODE: begin
                    if (!is_prefix) begin
                        op_q      <= mem_rdata;
                        imm_len_q <= rom_len;
                    end
                end
                CB: begin
                    op_q <= mem_rdata;
                    cb_q <= 1'b1;
                end
                IMM_LO:  imm_lo_q <= mem_rdata;
                IMM_HI:  imm_hi_q <= mem_rdata;
                default: ;
            endcase
        end
    end

    assign mem_req     = in_fetch;
    assign mem_addr    = fetch_addr;
    assign instr_valid = (state == HOLD);
    assign instr_op    = op_q;
    assign instr_cb    = cb_q;
    assign instr_imm   = {imm_hi_q, imm_lo_q};
    assign instr_len   = len_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, hand-written
// flush/handshake/reset sequences and randomized fetches against a model.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        fetch_start;
    logic        flush;
    logic [15:0] r_pc;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        pc_wen;
    logic [15:0] w_pc;
    logic        ir_wen;
    logic [7:0]  w_ir;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_op;
    logic        instr_cb;
    logic [15:0] instr_imm;
    logic [1:0]  instr_len;

    instr_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_start (fetch_start),
        .flush       (flush),
        .r_pc        (r_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .pc_wen      (pc_wen),
        .w_pc        (w_pc),
        .ir_wen      (ir_wen),
        .w_ir        (w_ir),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_cb    (instr_cb),
        .instr_imm   (instr_imm),
        .instr_len   (instr_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [7:0]  b0, b1, b2;
        int          w0, w1, w2;
        logic [7:0]  op;
        logic        cb;
        logic [15:0] imm;
        logic [1:0]  len;
        int          lat;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [0:65535];
    int         wait_q[$];
    bit         rd_active = 0;
    int         wcnt      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory with per-read wait states taken from wait_q (default zero-wait).
    task automatic mem_respond();
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
        if (!mem_req) begin
            rd_active = 0;
            return;
        end
        if (!rd_active) begin
            rd_active = 1;
            wcnt = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
        end
        if (wcnt == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr];
            rd_active = 0;
        end else begin
            wcnt--;
        end
    endtask

    task automatic to_sample();
        @(negedge clk);
        mem_respond();
        #1;
    endtask

    task automatic to_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"},  {mem_req, pc_wen, ir_wen, instr_valid}, 0);
        check({name, "_addr"}, {mem_addr, w_pc}, 0);
        check({name, "_ir"},   {w_ir, instr_op, instr_cb, instr_len}, 0);
        check({name, "_imm"},  instr_imm, 0);
    endtask

    function automatic int model_imm_len(input logic [7:0] op);
        if (op inside {8'h01, 8'h11, 8'h21, 8'h31, 8'h08, 8'hC2, 8'hC3, 8'hCA,
                       8'hD2, 8'hDA, 8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC, 8'hEA, 8'hFA})
            return 2;
        if (op inside {8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
                       8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38, 8'hC6, 8'hCE,
                       8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE, 8'hE0, 8'hF0,
                       8'hE8, 8'hF8})
            return 1;
        return 0;
    endfunction

    function automatic vec_t mk(input logic [15:0] pc, input logic [7:0] b0, b1, b2,
                                input int w0, w1, w2, input logic [7:0] op, input logic cb,
                                input logic [15:0] imm, input logic [1:0] len, input int lat);
        vec_t v;
        v.pc = pc; v.b0 = b0; v.b1 = b1; v.b2 = b2;
        v.w0 = w0; v.w1 = w1; v.w2 = w2;
        v.op = op; v.cb = cb; v.imm = imm; v.len = len; v.lat = lat;
        return v;
    endfunction

    // Reference: what the instruction at pc decodes to and how long it takes.
    function automatic vec_t model_vec(input logic [15:0] pc, input logic [7:0] b0, b1, b2,
                                       input int w0, w1, w2);
        int   n;
        vec_t v;
        v = mk(pc, b0, b1, b2, w0, w1, w2, 8'h00, 1'b0, 16'h0000, 2'd0, 0);
        if (b0 == 8'hCB) begin
            v.cb  = 1'b1;
            v.op  = b1;
            v.len = 2'd2;
        end else begin
            n     = model_imm_len(b0);
            v.op  = b0;
            v.imm = (n == 2) ? {b2, b1} : (n == 1) ? {8'h00, b1} : 16'h0000;
            v.len = 2'(1 + n);
        end
        v.lat = 1 + (w0 + 1) + ((v.len >= 2) ? w1 + 1 : 0) + ((v.len == 3) ? w2 + 1 : 0);
        return v;
    endfunction

    task automatic run_instr(input vec_t v, input bit b2b);
        logic [15:0] a;
        int          npc, nir;
        bit          done;
        a = v.pc;          mem[a] = v.b0;
        a = v.pc + 16'd1;  mem[a] = v.b1;
        a = v.pc + 16'd2;  mem[a] = v.b2;
        wait_q.delete();
        wait_q.push_back(v.w0);
        if (v.len >= 2) wait_q.push_back(v.w1);
        if (v.len == 3) wait_q.push_back(v.w2);
        r_pc        = v.pc;
        fetch_start = 1'b1;
        instr_ready = b2b;
        npc = 0; nir = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            to_sample();
            if (pc_wen) begin
                a = v.pc + 16'(npc);
                check("mem_addr_at_ack", mem_addr, a);
                a = v.pc + 16'(npc + 1);
                check("w_pc", w_pc, a);
                npc++;
            end
            if (ir_wen) begin
                check("w_ir", w_ir, v.op);
                nir++;
            end
            if (c > 0 && instr_valid) begin
                check("valid_latency", c, v.lat);
                check("instr_op", instr_op, v.op);
                check("instr_cb", instr_cb, v.cb);
                check("instr_imm", instr_imm, v.imm);
                check("instr_len", instr_len, v.len);
                check("pc_write_count", npc, v.len);
                check("ir_write_count", nir, 1);
                check("no_req_in_hold", mem_req, 0);
                done = 1;
            end
            to_edge();
            if (c == 0) begin
                fetch_start = 1'b0;
                instr_ready = 1'b0;
            end
        end
        check("valid_within_budget", done, 1);
    endtask

    task automatic accept();
        instr_ready = 1'b1;
        to_sample();
        check("accept_valid", instr_valid, 1);
        to_edge();
        instr_ready = 1'b0;
        to_sample();
        check("accept_idle", {instr_valid, mem_req}, 0);
        to_edge();
    endtask

    vec_t dir_vec[8];
    vec_t rv;

    initial begin
        rst = 1'b0; fetch_start = 1'b0; flush = 1'b0; r_pc = 16'h0000;
        instr_ready = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
        #1 rst = 1'b1;
        #1 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        dir_vec[0] = mk(16'h0100, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 16'h0000, 2'd1, 2);
        dir_vec[1] = mk(16'h0200, 8'h3E, 8'h42, 8'h99, 2, 2, 0, 8'h3E, 0, 16'h0042, 2'd2, 7);
        dir_vec[2] = mk(16'hFFFE, 8'hC3, 8'h34, 8'h12, 0, 0, 0, 8'hC3, 0, 16'h1234, 2'd3, 4);
        dir_vec[3] = mk(16'h0300, 8'hCB, 8'h37, 8'h55, 0, 0, 0, 8'h37, 1, 16'h0000, 2'd2, 3);
        dir_vec[4] = mk(16'h1234, 8'h21, 8'hCD, 8'hAB, 1, 0, 3, 8'h21, 0, 16'hABCD, 2'd3, 8);
        dir_vec[5] = mk(16'h8000, 8'h18, 8'hFE, 8'h77, 0, 1, 0, 8'h18, 0, 16'h00FE, 2'd2, 4);
        dir_vec[6] = mk(16'h4000, 8'hCB, 8'h11, 8'h3E, 3, 1, 0, 8'h11, 1, 16'h0000, 2'd2, 7);
        dir_vec[7] = mk(16'h7FFF, 8'hE0, 8'h80, 8'h01, 0, 0, 0, 8'hE0, 0, 16'h0080, 2'd2, 3);

        // Even entries start from IDLE, odd ones ride the back-to-back path.
        for (int i = 0; i < 8; i++) begin
            if (i > 0 && (i % 2) == 0) accept();
            run_instr(dir_vec[i], (i % 2) == 1);
        end
        accept();

        // Flush coinciding with an ack in IMM_LO; a start in that cycle is ignored.
        mem[16'h0400] = 8'h3E;
        mem[16'h0401] = 8'h55;
        wait_q.delete();
        r_pc = 16'h0400;
        fetch_start = 1'b1;
        to_sample(); to_edge();
        fetch_start = 1'b0;
        to_sample();
        check("flush_pre_opcode_ack", pc_wen, 1);
        to_edge();
        flush = 1'b1;
        fetch_start = 1'b1;
        to_sample();
        check("flush_cycle_state", {mem_req, mem_ack, mem_addr}, {2'b11, 16'h0401});
        check("flush_no_pc_wen", pc_wen, 0);
        check("flush_no_ir_wen", ir_wen, 0);
        to_edge();
        flush = 1'b0;
        fetch_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            to_sample();
            check("flush_idle", {mem_req, instr_valid}, 0);
            to_edge();
        end

        // Handshake: outputs hold while ready is low.
        run_instr(mk(16'h0500, 8'h01, 8'hEF, 8'hBE, 0, 0, 0, 8'h01, 0, 16'hBEEF, 2'd3, 4), 0);
        for (int k = 0; k < 5; k++) begin
            to_sample();
            check("hold_valid", instr_valid, 1);
            check("hold_stable", {instr_op, instr_cb, instr_imm, instr_len}, {8'h01, 1'b0, 16'hBEEF, 2'd3});
            check("hold_no_req", mem_req, 0);
            to_edge();
        end

        // Ready and start together, then reset while waiting in IMM_HI.
        mem[16'h0600] = 8'hC3;
        mem[16'h0601] = 8'h00;
        mem[16'h0602] = 8'h80;
        wait_q.delete();
        wait_q.push_back(0); wait_q.push_back(0); wait_q.push_back(3);
        r_pc = 16'h0600;
        instr_ready = 1'b1;
        fetch_start = 1'b1;
        to_sample(); to_edge();
        instr_ready = 1'b0;
        fetch_start = 1'b0;
        to_sample();
        check("b2b_opcode_req", {mem_req, mem_addr}, {1'b1, 16'h0600});
        check("b2b_valid_dropped", instr_valid, 0);
        to_edge();
        to_sample(); to_edge();
        to_sample();
        check("imm_hi_waiting", {mem_req, mem_ack, mem_addr}, {2'b10, 16'h0602});
        rst = 1'b1;
        #1 check_all_zero("rst_mid_fetch");
        to_edge();
        rst = 1'b0;
        wait_q.delete();
        to_sample();
        check("after_rst_idle", {mem_req, instr_valid}, 0);
        to_edge();

        // Randomized fetches against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [7:0] b0;
            bit         b2b;
            b0  = ($urandom_range(3) == 0) ? 8'hCB : 8'($urandom);
            rv  = model_vec(16'($urandom), b0, 8'($urandom), 8'($urandom),
                            $urandom_range(2), $urandom_range(2), $urandom_range(2));
            b2b = (i > 0) && ($urandom_range(1) == 1);
            if (i > 0 && !b2b) accept();
            run_instr(rv, b2b);
        end
        accept();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
